// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command frame transmitter.
// Holds the transmitter FSM state encoding and the known command codes.
package cmd_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_GAP    = 3'd5
   } state_t;

   localparam logic [7:0] RF_WR   = 8'hAA;
   localparam logic [7:0] RF_RD   = 8'hBB;
   localparam logic [7:0] ALU_OP  = 8'hCC;
   localparam logic [7:0] ALU_NOP = 8'hDD;

endpackage

// File: rtl/frame_parity_calc.sv
// Parity bit for one UART data field of any width.
// odd=0 gives even parity (XOR of the field), odd=1 gives odd parity (XNOR).
module frame_parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  odd,
   output logic                  parity
);

   assign parity = (^data) ^ odd;

endmodule

// File: rtl/cmd_frame_tx.sv
// Serialises one command frame plus up to MAX_OPS operand frames as UART frames.
// Define CMD_FRAME_TX_GAP_EN to insert GAP_BITS idle bit-times between frames.
module cmd_frame_tx
   import cmd_frame_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_OPS    = 3,
   parameter int GAP_BITS   = 1,
   localparam int OCW       = $clog2(MAX_OPS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [DATA_WIDTH-1:0]         cmd_code,
   input  logic [MAX_OPS*DATA_WIDTH-1:0] op_data,
   input  logic [OCW-1:0]                op_cnt,
   input  logic                          par_en,
   input  logic                          par_typ,
   input  logic                          stop2,
   output logic                          tx_out,
   output logic                          busy,
   output logic                          cmd_done,
   output state_t                        state
);

   localparam int BW = $clog2(DATA_WIDTH);

   // Handshake: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both 1; cmd_ready is only offered in IDLE with no command held.
   state_t                        state_q, state_d;
   logic [BW-1:0]                 bit_q, bit_d;
   logic [OCW-1:0]                frame_q, frame_d;
   logic                          stop_q, stop_d;
   logic                          tx_d, busy_d, done_d;
   logic [DATA_WIDTH-1:0]         code_q;
   logic [MAX_OPS*DATA_WIDTH-1:0] ops_q;
   logic [OCW-1:0]                cnt_q;
   logic                          par_en_q, par_typ_q, stop2_q;
   logic [DATA_WIDTH-1:0]         cur_frame;
   logic                          par_bit;
   logic                          accept;

`ifdef CMD_FRAME_TX_GAP_EN
   localparam int GW = $clog2(GAP_BITS + 1);
   logic [GW-1:0] gap_q, gap_d;
`else
   logic gap_unused;
   assign gap_unused = (GAP_BITS != 0);
`endif

   assign cmd_ready = (state_q == ST_IDLE) && !busy_q_w();
   assign accept    = cmd_valid && cmd_ready;
   assign state     = state_q;

   function automatic logic busy_q_w();
      return busy;
   endfunction

   // Frame 0 is the command code, frame k>0 is operand k-1.
   always_comb begin
      cur_frame = code_q;
      for (int i = 0; i < MAX_OPS; i++) begin
         if (frame_q == OCW'(i + 1)) cur_frame = ops_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   frame_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data   (cur_frame),
      .odd    (par_typ_q),
      .parity (par_bit)
   );

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      busy_d  = busy;
`ifdef CMD_FRAME_TX_GAP_EN
      gap_d   = gap_q;
`endif
      if (accept)        busy_d = 1'b1;
      else if (cmd_done) busy_d = 1'b0;

      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               // busy without cmd_done means a captured command is waiting
               if (busy && !cmd_done) begin
                  state_d = ST_START;
                  frame_d = '0;
               end
            end
            ST_START: begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
            ST_DATA: begin
               if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
                  stop_d  = 1'b0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
            ST_PARITY: begin
               state_d = ST_STOP;
               stop_d  = 1'b0;
            end
            ST_STOP: begin
               if (stop2_q && !stop_q) begin
                  stop_d = 1'b1;
               end else if (frame_q != cnt_q) begin
                  frame_d = frame_q + 1'b1;
`ifdef CMD_FRAME_TX_GAP_EN
                  state_d = ST_GAP;
                  gap_d   = '0;
`else
                  state_d = ST_START;
`endif
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
`ifdef CMD_FRAME_TX_GAP_EN
            ST_GAP: begin
               if (gap_q == GW'(GAP_BITS - 1)) state_d = ST_START;
               else                            gap_d   = gap_q + 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = cur_frame[bit_d];
         ST_PARITY: tx_d = par_bit;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         bit_q     <= '0;
         frame_q   <= '0;
         stop_q    <= 1'b0;
         tx_out    <= 1'b1;
         busy      <= 1'b0;
         cmd_done  <= 1'b0;
         code_q    <= '0;
         ops_q     <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         stop2_q   <= 1'b0;
`ifdef CMD_FRAME_TX_GAP_EN
         gap_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         frame_q  <= frame_d;
         stop_q   <= stop_d;
         tx_out   <= tx_d;
         busy     <= busy_d;
         cmd_done <= done_d;
`ifdef CMD_FRAME_TX_GAP_EN
         gap_q    <= gap_d;
`endif
         if (accept) begin
            code_q    <= cmd_code;
            ops_q     <= op_data;
            cnt_q     <= (op_cnt > OCW'(MAX_OPS)) ? OCW'(MAX_OPS) : op_cnt;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            stop2_q   <= stop2;
         end
      end
   end

endmodule
